// File: rtl/hlt_drain_ctrl_pkg.sv
// Purpose : shared halt-sequencer types and helpers (state enum, PC width, index-width helper).
// Latency : n/a (declarations only).
// Backpressure: n/a. Also consumed by the hazard unit for freeze signalling.
package hlt_drain_ctrl_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } hlt_state_t;

    // Bits needed to index n entries; never returns 0 so degenerate sizes still get a 1-bit field.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/hlt_drain_ctrl_if.sv
// Purpose : bundle between the core (ID / hazard unit / mem system) and the halt sequencer.
// Latency : n/a (wires only).
// Backpressure: none; stall_in/flush_in/mem_busy are level qualifiers, cf_req/cf_ack a req/ack pair.
// Ports (master = core side driving the sequencer, slave = hlt_drain_ctrl):
//   hlt_dec, hlt_pc, stall_in, flush_in, mem_busy, cf_ack -> sequencer
//   freeze_if, cf_req, cf_idx, hlt, pc                    <- sequencer
interface hlt_drain_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 3
);
    logic              hlt_dec;
    logic [PC_W-1:0]   hlt_pc;
    logic              stall_in;
    logic              flush_in;
    logic              mem_busy;
    logic              cf_ack;
    logic              freeze_if;
    logic              cf_req;
    logic [IDX_W-1:0]  cf_idx;
    logic              hlt;
    logic [PC_W-1:0]   pc;

    modport master (
        output hlt_dec, hlt_pc, stall_in, flush_in, mem_busy, cf_ack,
        input  freeze_if, cf_req, cf_idx, hlt, pc
    );

    modport slave (
        input  hlt_dec, hlt_pc, stall_in, flush_in, mem_busy, cf_ack,
        output freeze_if, cf_req, cf_idx, hlt, pc
    );
endinterface

// File: rtl/hlt_drain_ctrl_dcache_sweep.sv
// Purpose : walks D-cache set indices 0..DC_SETS-1, one writeback request per set.
// Latency : req is combinational from i_en; index advances on the edge of each ack.
// Backpressure: holds o_req/o_idx until i_ack; o_done pulses with the ack of the last set.
// Ports: i_clk, i_rst_n, i_en (sweep active), i_ack (line written back), o_req, o_idx, o_done.
module hlt_drain_ctrl_dcache_sweep #(
    parameter int DC_SETS = 8,
    parameter int IDX_W   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_ack,
    output logic             o_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_done
);
    logic [IDX_W-1:0] r_idx;
    logic             w_step;

    // Acks outside an active sweep are ignored.
    assign w_step = i_en & i_ack;

    // DC_SETS is a power of two, so the last increment wraps back to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (w_step) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_req  = i_en;
    assign o_idx  = r_idx;
    assign o_done = w_step & (r_idx == IDX_W'(DC_SETS - 1));
endmodule

// File: rtl/hlt_drain_ctrl.sv
// Purpose : halt sequencer: on an accepted HLT freezes fetch, drains the pipe, waits for memory idle,
//           optionally sweeps dirty D-cache lines (DCACHE_FLUSH_ON_HLT_EN), then raises sticky hlt/pc.
// Latency / backpressure: hlt rises PIPE_DEPTH cycles after acceptance when unstalled and mem idle;
//           stall_in pauses the drain count, mem_busy holds the final drain step, flush_in aborts DRAIN.
// Ports: i_clk, i_rst_n (async active-low), io_bus (hlt_drain_ctrl_if.slave).
module hlt_drain_ctrl
    import hlt_drain_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int DC_SETS    = 8,
    parameter int PC_W       = hlt_drain_ctrl_pkg::PC_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hlt_drain_ctrl_if.slave   io_bus
);
    localparam int CNT_W = clog2(PIPE_DEPTH);
    localparam int IDX_W = clog2(DC_SETS);

    hlt_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [PC_W-1:0]  r_pc,    w_pc_nxt;
    logic             r_hlt,   w_hlt_nxt;
    logic             w_accept;
    logic             w_drain_done;

    // An HLT seen while stalled or squashed is not taken; ID re-presents it.
    assign w_accept     = io_bus.hlt_dec & ~io_bus.stall_in & ~io_bus.flush_in;
    // Flush has priority: a squashed HLT must never reach the halted state.
    assign w_drain_done = (r_cnt == '0) & ~io_bus.stall_in & ~io_bus.mem_busy & ~io_bus.flush_in;

`ifdef DCACHE_FLUSH_ON_HLT_EN
    logic w_sweep_done;

    hlt_drain_ctrl_dcache_sweep #(
        .DC_SETS (DC_SETS),
        .IDX_W   (IDX_W)
    ) u_sweep (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_state == ST_FLUSH),
        .i_ack   (io_bus.cf_ack),
        .o_req   (io_bus.cf_req),
        .o_idx   (io_bus.cf_idx),
        .o_done  (w_sweep_done)
    );
`else
    logic w_unused;
    assign w_unused      = io_bus.cf_ack;
    assign io_bus.cf_req = 1'b0;
    assign io_bus.cf_idx = {IDX_W{1'b0}};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_hlt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pc    <= w_pc_nxt;
            r_hlt   <= w_hlt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        w_hlt_nxt   = r_hlt;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    w_pc_nxt    = io_bus.hlt_pc;
                    w_cnt_nxt   = CNT_W'(PIPE_DEPTH - 1);
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (io_bus.flush_in) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else if (!io_bus.stall_in && r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_drain_done) begin
`ifdef DCACHE_FLUSH_ON_HLT_EN
                    w_state_nxt = ST_FLUSH;
`else
                    w_state_nxt = ST_HALTED;
                    w_hlt_nxt   = 1'b1;
`endif
                end
            end
`ifdef DCACHE_FLUSH_ON_HLT_EN
            ST_FLUSH: begin
                if (w_sweep_done) begin
                    w_state_nxt = ST_HALTED;
                    w_hlt_nxt   = 1'b1;
                end
            end
`endif
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Decoded from registered state, so freeze_if is glitch-free.
    assign io_bus.freeze_if = (r_state != ST_RUN);
    assign io_bus.hlt       = r_hlt;
    assign io_bus.pc        = r_pc;
endmodule

// File: tb/tb_hlt_drain_ctrl.sv
module tb_hlt_drain_ctrl;
    import hlt_drain_ctrl_pkg::*;

    localparam int PD = 4;
    localparam int NS = 8;
    localparam int PW = 16;
    localparam int IW = clog2(NS);
    localparam int NCYC = 80;
`ifdef DCACHE_FLUSH_ON_HLT_EN
    localparam int FLUSH_CYC = 3 * NS;   // responder acks every set 2 cycles after its request
`else
    localparam int FLUSH_CYC = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [15:0] pc;
        int          at;
    } exp_t;
    exp_t q[$];

    hlt_drain_ctrl_if #(.PC_W(PW), .IDX_W(IW)) bus ();

    hlt_drain_ctrl #(.PIPE_DEPTH(PD), .DC_SETS(NS), .PC_W(PW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_freeze"}, 32'(bus.freeze_if), 0);
        chk({tag, "_cf_req"}, 32'(bus.cf_req), 0);
        chk({tag, "_cf_idx"}, 32'(bus.cf_idx), 0);
        chk({tag, "_hlt"},    32'(bus.hlt), 0);
        chk({tag, "_pc"},     32'(bus.pc), 0);
    endtask

    task automatic drive_idle();
        bus.hlt_dec  = 1'b0;
        bus.hlt_pc   = 16'($urandom);
        bus.stall_in = 1'(($urandom_range(3) == 0));
        bus.flush_in = 1'(($urandom_range(3) == 0));
        bus.mem_busy = 1'($urandom_range(1));
    endtask

    // Full reset: asserted away from clock edges, outputs checked before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("reset");
        step();
        #2;
        rst_n = 1'b1;
    endtask

    // Response monitor: every rising edge of hlt must match the oldest expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.hlt && !prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hlt: hlt rose with pc 0x%0h at cycle %0d, none expected", bus.pc, cyc);
                end else begin
                    e = q.pop_front();
                    chk("hlt_pc", 32'(bus.pc), 32'(e.pc));
                    chk("hlt_cycle", 32'(cyc), 32'(e.at));
                end
            end
            prev = bus.hlt;
        end
    end

    // D-cache model: acks each request 2 cycles later, checks the set order,
    // and sprinkles stray acks while no request is outstanding.
    initial begin
        int wc;
        int exp_idx;
        wc = 0;
        exp_idx = 0;
        bus.cf_ack = 1'b0;
        forever begin
            step();
            if (rst_n && bus.cf_req) begin
                if (wc == 2) begin
                    chk("cf_idx_order", 32'(bus.cf_idx), 32'(exp_idx));
                    exp_idx = (exp_idx + 1) % NS;
                    bus.cf_ack = 1'b1;
                    wc = 0;
                end else begin
                    bus.cf_ack = 1'b0;
                    wc++;
                end
            end else begin
                wc = 0;
                exp_idx = 0;
                bus.cf_ack = 1'($urandom_range(1));
            end
        end
    end

    // One HLT episode. Halt cycle is derived from the rules: counting from the first cycle after
    // acceptance, the HLT completes draining in the first non-stalled, memory-idle cycle preceded
    // by at least PIPE_DEPTH-1 non-stalled cycles; a flush at or before that cycle cancels it.
    task automatic episode(input logic [15:0] p, input int stall_pct, input int busy_pct,
                           input int st_from, input int st_len, input int bz_from, input int bz_len,
                           input int flush_at, input int reset_at, input bit fresh);
        bit stl[NCYC];
        bit bsy[NCYC];
        int t, ns, a, h;
        bit aborted;
        if (fresh) do_reset();
        for (int i = 0; i < NCYC; i++) begin
            stl[i] = (i < 40) && ($urandom_range(99) < stall_pct);
            bsy[i] = (i < 40) && ($urandom_range(99) < busy_pct);
            if (i >= st_from && i < st_from + st_len) stl[i] = 1'b1;
            if (i >= bz_from && i < bz_from + bz_len) bsy[i] = 1'b1;
        end
        t = -1;
        ns = 0;
        for (int i = 0; i < NCYC; i++) begin
            if (t < 0) begin
                if (!stl[i] && !bsy[i] && ns >= PD - 1) t = i;
                if (!stl[i]) ns++;
            end
        end
        aborted = (flush_at >= 0) && (flush_at <= t);

        repeat ($urandom_range(1, 4)) begin
            drive_idle();
            step();
        end
        // Decoy HLT under stall or flush must not be taken.
        bus.hlt_dec = 1'b1;
        bus.hlt_pc  = ~p;
        bus.stall_in = 1'($urandom_range(1));
        bus.flush_in = ~bus.stall_in;
        step();
        chk("decoy_ignored", 32'(bus.freeze_if), 0);

        bus.hlt_dec  = 1'b1;
        bus.hlt_pc   = p;
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.mem_busy = 1'($urandom_range(1));
        step();
        a = cyc;
        chk("freeze_on_accept", 32'(bus.freeze_if), 1);
        h = a + t + 1 + FLUSH_CYC;
        if (!aborted && (reset_at < 0 || h < a + reset_at)) q.push_back('{p, h});

        for (int i = 0; i < NCYC; i++) begin
            if (i == reset_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk_zero("async_reset");
                #1;
                rst_n = 1'b1;
            end
            bus.hlt_dec  = 1'b0;
            bus.hlt_pc   = 16'($urandom);
            bus.stall_in = stl[i];
            bus.mem_busy = bsy[i];
            bus.flush_in = (i == flush_at);
            step();
            if (i == flush_at && aborted) chk("freeze_drop_on_flush", 32'(bus.freeze_if), 0);
        end
        chk("hlt_pending_after_budget", 32'(q.size()), 0);
        q.delete();

        if (!aborted && reset_at < 0) begin
            for (int k = 0; k < 5; k++) begin
                chk("halted_hlt", 32'(bus.hlt), 1);
                chk("halted_pc", 32'(bus.pc), 32'(p));
                chk("halted_freeze", 32'(bus.freeze_if), 1);
                chk("halted_cf_req", 32'(bus.cf_req), 0);
                drive_idle();
                bus.hlt_dec = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        bus.hlt_dec  = 1'b0;
        bus.hlt_pc   = '0;
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.mem_busy = 1'b0;
        #3;
        // p, stall%, busy%, st_from, st_len, bz_from, bz_len, flush_at, reset_at, fresh
        episode(16'h0012, 0, 0, -1, 0, -1, 0, -1, -1, 1);   // plain halt
        episode(16'h0034, 0, 0,  1, 3, -1, 0, -1, -1, 1);   // 3-cycle stall mid-drain
        episode(16'h0040, 0, 0, -1, 0, -1, 0,  1, -1, 1);   // speculative HLT flushed
        episode(16'h0020, 0, 0, -1, 0, -1, 0, -1, -1, 0);   // later HLT in same reset
        episode(16'h0056, 0, 0, -1, 0,  3, 10, -1, -1, 1);  // memory busy at drain end
        episode(16'h0078, 0, 0, -1, 0, -1, 0,  3,  -1, 1);  // flush on the final drain cycle
        episode(16'h009A, 0, 0, -1, 0, -1, 0, -1,  2, 1);   // reset mid-drain
        episode(16'h00BC, 0, 0, -1, 0, -1, 0, -1, 10, 0);   // reset in sweep / halted
        episode(16'h00DE, 0, 0, -1, 0, -1, 0, -1, -1, 0);   // recovery after async reset
        for (int n = 0; n < 8; n++) begin
            episode(16'($urandom), 30, 30, -1, 0, -1, 0,
                    ($urandom_range(2) == 0) ? int'($urandom_range(8)) : -1, -1, 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
